eth_mdio_sched: RTL
===================

ETH_MDIO_SCHED -- requirements
Module: eth_mdio_sched

Interface
REQ-001 SHALL have parameter G_POLL_PERIOD, default 1000000, clk cycles between status polls; 0 disables polling.
REQ-002 SHALL have parameter G_POLL_APHY, default 5'h06, PHY address used by status polls.
REQ-003 SHALL have parameter G_POLL_AREG, default 5'h01, register address read by status polls.
REQ-004 SHALL have parameter G_TIMEOUT, default 4096, max cycles in START waiting for mdio_busy.
REQ-005 SHALL have ports: clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: reqN_valid  in  1  requester N (N=0,1) command pending.
REQ-008 SHALL have ports: reqN_dir  in  1  1 = write (tx), 0 = read (rx).
REQ-009 SHALL have ports: reqN_aphy  in  5, reqN_areg  in  5, reqN_txd  in  16  command fields.
REQ-010 SHALL have ports: reqN_ack  out  1  one-cycle pulse; command accepted, fields captured.
REQ-011 SHALL have ports: reqN_done  out  1  one-cycle pulse; transaction finished.
REQ-012 SHALL have ports: reqN_rxd  out  16  read data, valid from reqN_done until next reqN_done.
REQ-013 SHALL have ports: reqN_err  out  1  one-cycle pulse with reqN_done on timeout.
REQ-014 SHALL have ports: mdio_start  out  1, mdio_dir  out  1, mdio_aphy  out  5, mdio_areg  out  5, mdio_txd  out  16  to MDIO engine.
REQ-015 SHALL have ports: mdio_rxd  in  16, mdio_busy  in  1  from MDIO engine.
REQ-016 SHALL have ports: link_up  out  1  bit 2 of last successful poll read.
REQ-017 SHALL have ports: poll_rxd  out  16  last successful poll read data; poll_valid  out  1  one-cycle pulse on update.

Function
REQ-018 SHALL implement FSM IDLE -> START -> WAIT_DONE -> RESP -> IDLE.
REQ-019 SHALL, in IDLE, grant one source among {req0, req1, poll} by round-robin: search begins at source after last granted, order 0,1,2.
REQ-020 SHALL, on grant of reqN, pulse reqN_ack in grant cycle and register dir/aphy/areg/txd onto mdio_* outputs.
REQ-021 SHALL, on poll grant, drive mdio_dir=0, mdio_aphy=G_POLL_APHY, mdio_areg=G_POLL_AREG, mdio_txd=0.
REQ-022 SHALL hold mdio_start=1 throughout START and mdio_start=0 in all other states.
REQ-023 SHALL leave START for WAIT_DONE on first cycle mdio_busy=1.
REQ-024 SHALL leave START for RESP with error flag if G_TIMEOUT cycles elapse without mdio_busy=1.
REQ-025 SHALL leave WAIT_DONE for RESP on first cycle mdio_busy=0.
REQ-026 SHALL, in RESP (one cycle), capture mdio_rxd for read commands into reqN_rxd or poll_rxd, pulse reqN_done (and reqN_err if timeout) or poll_valid (only if no timeout), then return to IDLE.
REQ-027 SHALL update link_up = mdio_rxd[2] only on successful poll; unchanged on poll timeout.
REQ-028 SHALL leave reqN_rxd unchanged on write commands and timeouts.
REQ-029 SHALL keep mdio_* fields stable from grant until RESP.
REQ-030 SHALL run a 32-bit poll counter, incrementing every cycle, setting poll_pend and clearing to 0 when reaching G_POLL_PERIOD-1; poll_pend cleared on poll grant.
REQ-031 SHALL NOT accumulate polls: counter expiry while poll_pend=1 leaves one pending poll.
REQ-032 SHALL ignore reqN_valid while FSM not in IDLE; requester holds valid until ack.
REQ-033 SHALL give minimum latency reqN_valid(IDLE, sole source) -> reqN_ack 0 cycles (same cycle, combinational), mdio_start 1 cycle later.

Reset
REQ-034 SHALL, on rst=0, asynchronously force: FSM IDLE, all mdio_* = 0, all ack/done/err/poll_valid = 0, reqN_rxd = 0, poll_rxd = 0, link_up = 0, poll counter = 0, poll_pend = 0, round-robin pointer to source 0.
REQ-035 SHALL abandon any in-flight transaction on reset with no done pulse afterwards.

Verification
REQ-036 SHALL verify: req0 write aphy=06, areg=0B, txd=8FFA, engine busy 100 cycles -> one ack, mdio_start until busy, req0_done one cycle after busy falls, req0_rxd unchanged.
REQ-037 SHALL verify: req1 read, engine returns mdio_rxd=1234 -> req1_rxd=1234 at req1_done, req1_err=0.
REQ-038 SHALL verify: req0 and req1 valid continuously -> grants alternate 0,1,0,1; no source served twice consecutively while other waits.
REQ-039 SHALL verify: G_POLL_PERIOD=50, engine returns 0004 -> poll_valid pulses, link_up=1, poll_rxd=0004; then 0000 -> link_up=0.
REQ-040 SHALL verify: mdio_busy tied 0, G_TIMEOUT=16 -> req0_done with req0_err 16 cycles after START entry, FSM back to IDLE.
REQ-041 SHALL verify: rst=0 asserted during WAIT_DONE -> all outputs at reset values immediately, no done pulse after release.

Source files
------------

// File: rtl/eth_mdio_sched.sv
// MDIO command scheduler: round-robin arbitration between two requesters and a
// periodic status poll, sequencing one transaction at a time into an MDIO engine.
module eth_mdio_sched #(
  parameter int unsigned G_POLL_PERIOD = 1000000,
  parameter logic [4:0]  G_POLL_APHY   = 5'h06,
  parameter logic [4:0]  G_POLL_AREG   = 5'h01,
  parameter int unsigned G_TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_dir,
  input  logic [4:0]  req0_aphy,
  input  logic [4:0]  req0_areg,
  input  logic [15:0] req0_txd,
  output logic        req0_ack,
  output logic        req0_done,
  output logic [15:0] req0_rxd,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic        req1_dir,
  input  logic [4:0]  req1_aphy,
  input  logic [4:0]  req1_areg,
  input  logic [15:0] req1_txd,
  output logic        req1_ack,
  output logic        req1_done,
  output logic [15:0] req1_rxd,
  output logic        req1_err,
  output logic        mdio_start,
  output logic        mdio_dir,
  output logic [4:0]  mdio_aphy,
  output logic [4:0]  mdio_areg,
  output logic [15:0] mdio_txd,
  input  logic [15:0] mdio_rxd,
  input  logic        mdio_busy,
  output logic        link_up,
  output logic [15:0] poll_rxd,
  output logic        poll_valid
);

  // state     | meaning
  // S_IDLE    | arbitrate; grant one source and latch its command
  // S_START   | mdio_start high, waiting for engine busy or timeout
  // S_WAIT    | engine busy, waiting for it to finish
  // S_RESP    | one cycle: deliver done/err/data, back to idle
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  localparam logic [1:0]  SRC_REQ0 = 2'd0;
  localparam logic [1:0]  SRC_REQ1 = 2'd1;
  localparam logic [1:0]  SRC_POLL = 2'd2;
  localparam logic [31:0] LP_PERIOD_M1 = (G_POLL_PERIOD == 0) ? 32'd0 : 32'(G_POLL_PERIOD - 1);
  localparam logic [31:0] LP_TMO_M1    = (G_TIMEOUT == 0) ? 32'd0 : 32'(G_TIMEOUT - 1);
  localparam bit          LP_POLL_EN   = (G_POLL_PERIOD != 0);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_src;
  logic [1:0]  r_rr_ptr;
  logic        r_err;
  logic [31:0] r_tmo;
  logic [31:0] r_poll_cnt;
  logic        r_poll_pend;
  logic        r_mdio_dir;
  logic [4:0]  r_mdio_aphy;
  logic [4:0]  r_mdio_areg;
  logic [15:0] r_mdio_txd;
  logic [15:0] r_req0_rxd;
  logic [15:0] r_req1_rxd;
  logic [15:0] r_poll_rxd;
  logic        r_link_up;

  logic [2:0]  w_req;
  logic        w_gnt_vld;
  logic [1:0]  w_gnt_src;
  logic        w_grant;
  logic        w_tmo_hit;
  logic        w_resp;
  logic        w_capture;
  logic        w_poll_ok;
  logic        w_poll_exp;

  assign w_req = {r_poll_pend, req1_valid, req0_valid};

  // Search starts at the source after the last one granted.
  always_comb begin
    w_gnt_vld = |w_req;
    w_gnt_src = SRC_REQ0;
    case (r_rr_ptr)
      2'd1: begin
        if (w_req[1])      w_gnt_src = SRC_REQ1;
        else if (w_req[2]) w_gnt_src = SRC_POLL;
        else               w_gnt_src = SRC_REQ0;
      end
      2'd2: begin
        if (w_req[2])      w_gnt_src = SRC_POLL;
        else if (w_req[0]) w_gnt_src = SRC_REQ0;
        else               w_gnt_src = SRC_REQ1;
      end
      default: begin
        if (w_req[0])      w_gnt_src = SRC_REQ0;
        else if (w_req[1]) w_gnt_src = SRC_REQ1;
        else               w_gnt_src = SRC_POLL;
      end
    endcase
  end

  assign w_grant = (r_state == S_IDLE) && w_gnt_vld;

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_hit   = 1'b0;
    case (r_state)
      S_IDLE:  if (w_gnt_vld) w_state_nxt = S_START;
      S_START: begin
        if (mdio_busy) begin
          w_state_nxt = S_WAIT;
        end else if (r_tmo == 32'd0) begin
          w_state_nxt = S_RESP;
          w_tmo_hit   = 1'b1;
        end
      end
      S_WAIT:  if (!mdio_busy) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_src       <= SRC_REQ0;
      r_rr_ptr    <= SRC_REQ0;
      r_err       <= 1'b0;
      r_tmo       <= 32'd0;
      r_mdio_dir  <= 1'b0;
      r_mdio_aphy <= 5'd0;
      r_mdio_areg <= 5'd0;
      r_mdio_txd  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_src    <= w_gnt_src;
        r_rr_ptr <= (w_gnt_src == SRC_POLL) ? SRC_REQ0 : w_gnt_src + 2'd1;
        r_err    <= 1'b0;
        r_tmo    <= LP_TMO_M1;
        case (w_gnt_src)
          SRC_REQ0: begin
            r_mdio_dir  <= req0_dir;
            r_mdio_aphy <= req0_aphy;
            r_mdio_areg <= req0_areg;
            r_mdio_txd  <= req0_txd;
          end
          SRC_REQ1: begin
            r_mdio_dir  <= req1_dir;
            r_mdio_aphy <= req1_aphy;
            r_mdio_areg <= req1_areg;
            r_mdio_txd  <= req1_txd;
          end
          default: begin
            r_mdio_dir  <= 1'b0;
            r_mdio_aphy <= G_POLL_APHY;
            r_mdio_areg <= G_POLL_AREG;
            r_mdio_txd  <= 16'd0;
          end
        endcase
      end else if (r_state == S_START && !mdio_busy && r_tmo != 32'd0) begin
        r_tmo <= r_tmo - 32'd1;
      end
      if (w_tmo_hit) r_err <= 1'b1;
    end
  end

  // Result data is forwarded combinationally in the RESP cycle so it is valid
  // together with the done/poll_valid pulse, then held in the register.
  assign w_resp    = (r_state == S_RESP);
  assign w_capture = w_resp && !r_err && !r_mdio_dir;
  assign w_poll_ok = w_resp && !r_err && (r_src == SRC_POLL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req0_rxd <= 16'd0;
      r_req1_rxd <= 16'd0;
      r_poll_rxd <= 16'd0;
      r_link_up  <= 1'b0;
    end else begin
      if (w_capture && r_src == SRC_REQ0) r_req0_rxd <= mdio_rxd;
      if (w_capture && r_src == SRC_REQ1) r_req1_rxd <= mdio_rxd;
      if (w_poll_ok) begin
        r_poll_rxd <= mdio_rxd;
        r_link_up  <= mdio_rxd[2];
      end
    end
  end

  assign w_poll_exp = LP_POLL_EN && (r_poll_cnt == LP_PERIOD_M1);

  // A pending poll is a single flag, so expiries never stack up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_poll_cnt  <= 32'd0;
      r_poll_pend <= 1'b0;
    end else begin
      if (LP_POLL_EN) begin
        r_poll_cnt <= w_poll_exp ? 32'd0 : r_poll_cnt + 32'd1;
      end
      if (w_poll_exp) begin
        r_poll_pend <= 1'b1;
      end else if (w_grant && w_gnt_src == SRC_POLL) begin
        r_poll_pend <= 1'b0;
      end
    end
  end

  assign req0_ack   = w_grant && (w_gnt_src == SRC_REQ0);
  assign req1_ack   = w_grant && (w_gnt_src == SRC_REQ1);
  assign req0_done  = w_resp && (r_src == SRC_REQ0);
  assign req1_done  = w_resp && (r_src == SRC_REQ1);
  assign req0_err   = w_resp && r_err && (r_src == SRC_REQ0);
  assign req1_err   = w_resp && r_err && (r_src == SRC_REQ1);
  assign req0_rxd   = (w_capture && r_src == SRC_REQ0) ? mdio_rxd : r_req0_rxd;
  assign req1_rxd   = (w_capture && r_src == SRC_REQ1) ? mdio_rxd : r_req1_rxd;
  assign poll_valid = w_poll_ok;
  assign poll_rxd   = w_poll_ok ? mdio_rxd : r_poll_rxd;
  assign link_up    = w_poll_ok ? mdio_rxd[2] : r_link_up;

  assign mdio_start = (r_state == S_START);
  assign mdio_dir   = r_mdio_dir;
  assign mdio_aphy  = r_mdio_aphy;
  assign mdio_areg  = r_mdio_areg;
  assign mdio_txd   = r_mdio_txd;

endmodule
